multi_debounce_counter: RTL and testbench
=========================================

Name: multi_debounce_counter

Overview:
N-channel successor to the single-channel debounce/edge counter used on board switches and buttons. Each channel does the following:
- synchronises a raw level input;
- debounces it with a timed FSM;
- counts qualifying edges on both the raw (synchronised) and the debounced signal, for bounce characterisation.

Edge polarity is run-time selectable. Counter width, channel count and debounce time are parameters. Sits between board I/O pins and the display/LED logic.

Parameters:
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 8, width of each edge counter
- DB_TICKS, 2000000, stable cycles required before the debounced output changes (20 ms @ 100 MHz); must be >= 2
- TMR_W, $clog2(DB_TICKS), debounce timer width (derived, not overridden)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_lvl  in  N_CH  raw level inputs, asynchronous to i_clk
- i_clr  in  N_CH  per-channel synchronous clear of both counters of that channel
- i_mode  in  2  edge select: 00 rising, 01 falling, 10 both, 11 none (counting frozen)
- o_lvl_db  out  N_CH  debounced levels
- o_db_edge  out  N_CH  1-cycle pulse per qualifying debounced edge
- o_raw_count  out  N_CH*CNT_W  raw edge counts, channel c at [c*CNT_W +: CNT_W]
- o_db_count  out  N_CH*CNT_W  debounced edge counts, same packing

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops, FSMs, timers, counters and edge-history flops reach 0 / S_ZERO.
  - All outputs are 0.
- Synchroniser: 2-flop chain per channel; the second flop is the "synced" level s.
- Raw edge detection:
  - Compares s with its 1-cycle delayed copy; polarity is selected by i_mode.
  - A raw counter increments the cycle after the qualifying edge is visible on s.
- Debounce FSM per channel, states S_ZERO, S_WAIT1, S_ONE, S_WAIT0:
  - S_ZERO, s=1 -> S_WAIT1, timer <= DB_TICKS-1.
  - S_WAIT1: s=0 -> S_ZERO (no output change). s=1 and timer!=0 -> timer-1. s=1 and timer==0 -> S_ONE.
  - S_ONE / S_WAIT0: symmetric.
  - o_lvl_db = 1 in S_ONE and S_WAIT0, otherwise 0 (registered from state).
- Latency: for a clean step first sampled at edge k, o_lvl_db changes after edge k+DB_TICKS+2.
- o_db_edge: asserted for exactly the one cycle in which o_lvl_db has just changed and the change qualifies under i_mode. The debounced counter increments on that same edge.
- Counter priority per channel: i_clr > increment > hold.
  - Clear and an edge in the same cycle -> count becomes 0 (the edge is lost).
- Width: counters wrap modulo 2^CNT_W (max -> 0) unless DB_COUNT_SAT_EN is defined.
- i_mode change: takes effect on the next edge. FSM and o_lvl_db are unaffected by mode; edges occurring under 11 are never counted retroactively.
- Channels are fully independent; there is no cross-channel interaction.
- Reset mid-debounce: the FSM returns to S_ZERO and the timer is lost. A level still held high after release is re-debounced from scratch.

Optional Feature:
DB_COUNT_SAT_EN
- Defined: both counters saturate at 2^CNT_W-1 and hold until i_clr or reset.
- Undefined: both counters wrap to 0.
- o_db_edge still pulses at saturation.

Decomposition:
- Package multi_debounce_pkg:
  - enum db_state_t {S_ZERO, S_WAIT1, S_ONE, S_WAIT0}
  - enum edge_mode_t {EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_NONE=2'b11}
  - function edge_qualifies(prev, cur, mode)
- Sub-module debounce_channel: synchroniser, FSM, timer, o_lvl_db, o_db_edge for one channel. The top instantiates N_CH copies via generate and holds the counters.

Test Plan (bench uses DB_TICKS=4, CNT_W=4, N_CH=2):
- Reset then clean rise on ch0 at edge k, mode 00 -> o_lvl_db[0]=1 after edge k+6; one o_db_edge pulse; db_count0=1, raw_count0=1; ch1 all 0.
- Ch0 bounce 0-1-0-1 (1 cycle each), then held high, mode 00 -> raw_count0=2, db_count0=1, o_lvl_db rises only after the final high has been stable 4 cycles.
- Mode 10, 5 clean full pulses on ch1 -> db_count1=10, raw_count1=10; mode 11 with 3 more pulses -> counts unchanged.
- 17 clean rising pulses, mode 00 -> wrap build: count=1; DB_COUNT_SAT_EN build: count=15.
- i_clr[0] asserted in the same cycle as a qualifying o_db_edge[0] -> db_count0=0 on the next cycle; ch1 counts unaffected.
- i_rst asserted asynchronously mid-S_WAIT1 with i_lvl held high -> outputs 0 immediately; after release o_lvl_db rises DB_TICKS+2 edges after first sampling.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// Shared types and edge-qualification helper for the multi-channel debounce/edge counter.
package multi_debounce_pkg;

    // Bit 1 of the encoding is the debounced level, so the output decodes straight from the state flop.
    typedef enum logic [1:0] {
        S_ZERO  = 2'b00,
        S_WAIT1 = 2'b01,
        S_ONE   = 2'b10,
        S_WAIT0 = 2'b11
    } db_state_t;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    function automatic logic edge_qualifies(input logic prev, input logic cur, input edge_mode_t mode);
        logic q;
        case (mode)
            EDGE_RISE: q = ~prev & cur;
            EDGE_FALL: q = prev & ~cur;
            EDGE_BOTH: q = prev ^ cur;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: 2-flop synchroniser, timed debounce FSM, debounced-edge pulse and
// increment strobes for the raw and debounced edge counters held by the parent.
module debounce_channel
    import multi_debounce_pkg::*;
#(
    parameter int DB_TICKS = 2000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lvl,
    input  edge_mode_t i_mode,
    output logic       o_lvl_db,
    output logic       o_db_edge,
    output logic       o_raw_inc,
    output logic       o_db_inc
);
    localparam int TMR_W = $clog2(DB_TICKS);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DB_TICKS - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             sync_prev_q, sync_prev_d;
    logic             db_edge_q, db_edge_d;
    db_state_t        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q      <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
            db_edge_q   <= 1'b0;
            state_q     <= S_ZERO;
            timer_q     <= '0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            db_edge_q   <= db_edge_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        meta_d      = i_lvl;
        sync_d      = meta_q;
        sync_prev_d = sync_q;
        state_d     = state_q;
        timer_d     = timer_q;
        case (state_q)
            S_ZERO: begin
                if (sync_q) begin
                    state_d = S_WAIT1;
                    timer_d = TMR_LOAD;
                end
            end
            S_WAIT1: begin
                if (!sync_q)                state_d = S_ZERO;
                else if (timer_q != '0)     timer_d = timer_q - TMR_W'(1);
                else                        state_d = S_ONE;
            end
            S_ONE: begin
                if (!sync_q) begin
                    state_d = S_WAIT0;
                    timer_d = TMR_LOAD;
                end
            end
            S_WAIT0: begin
                if (sync_q)                 state_d = S_ONE;
                else if (timer_q != '0)     timer_d = timer_q - TMR_W'(1);
                else                        state_d = S_ZERO;
            end
            default: state_d = S_ZERO;
        endcase
        // The debounced counter steps on the same edge the level and the pulse change.
        o_db_inc  = edge_qualifies(state_q[1], state_d[1], i_mode);
        db_edge_d = o_db_inc;
        o_raw_inc = edge_qualifies(sync_prev_q, sync_q, i_mode);
    end

    assign o_lvl_db  = state_q[1];
    assign o_db_edge = db_edge_q;

endmodule

// File: rtl/multi_debounce_counter.sv
// N-channel debounced/raw edge counter. Define DB_COUNT_SAT_EN to make both
// counters saturate at all-ones instead of wrapping.
module multi_debounce_counter
    import multi_debounce_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int DB_TICKS = 2000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_CH-1:0]       i_lvl,
    input  logic [N_CH-1:0]       i_clr,
    input  logic [1:0]            i_mode,
    output logic [N_CH-1:0]       o_lvl_db,
    output logic [N_CH-1:0]       o_db_edge,
    output logic [N_CH*CNT_W-1:0] o_raw_count,
    output logic [N_CH*CNT_W-1:0] o_db_count
);
    edge_mode_t mode;
    assign mode = edge_mode_t'(i_mode);

    // Clear beats increment, so an edge coinciding with a clear is dropped.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic clr, input logic inc);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (clr) begin
            nxt = '0;
        end else if (inc) begin
`ifdef DB_COUNT_SAT_EN
            if (cnt != {CNT_W{1'b1}}) nxt = cnt + CNT_W'(1);
`else
            nxt = cnt + CNT_W'(1);
`endif
        end
        return nxt;
    endfunction

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             raw_inc, db_inc;
            logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d;
            logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

            debounce_channel #(
                .DB_TICKS (DB_TICKS)
            ) u_ch (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_lvl     (i_lvl[gi]),
                .i_mode    (mode),
                .o_lvl_db  (o_lvl_db[gi]),
                .o_db_edge (o_db_edge[gi]),
                .o_raw_inc (raw_inc),
                .o_db_inc  (db_inc)
            );

            always_comb begin
                raw_cnt_d = next_count(raw_cnt_q, i_clr[gi], raw_inc);
                db_cnt_d  = next_count(db_cnt_q, i_clr[gi], db_inc);
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    raw_cnt_q <= '0;
                    db_cnt_q  <= '0;
                end else begin
                    raw_cnt_q <= raw_cnt_d;
                    db_cnt_q  <= db_cnt_d;
                end
            end

            assign o_raw_count[gi*CNT_W +: CNT_W] = raw_cnt_q;
            assign o_db_count[gi*CNT_W +: CNT_W]  = db_cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_debounce_counter.sv
// Directed bench for multi_debounce_counter with N_CH=2, CNT_W=4, DB_TICKS=4.
module tb_multi_debounce_counter;
    localparam int N_CH = 2;
    localparam int CNT_W = 4;
    localparam int DB_TICKS = 4;

    logic             clk;
    logic             i_rst;
    logic [N_CH-1:0]  i_lvl;
    logic [N_CH-1:0]  i_clr;
    logic [1:0]       i_mode;
    logic [N_CH-1:0]  o_lvl_db;
    logic [N_CH-1:0]  o_db_edge;
    logic [N_CH*CNT_W-1:0] o_raw_count;
    logic [N_CH*CNT_W-1:0] o_db_count;

    int n_checks = 0;
    int n_fail = 0;

    multi_debounce_counter #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_lvl       (i_lvl),
        .i_clr       (i_clr),
        .i_mode      (i_mode),
        .o_lvl_db    (o_lvl_db),
        .o_db_edge   (o_db_edge),
        .o_raw_count (o_raw_count),
        .o_db_count  (o_db_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] lvl;
        logic [1:0] mode;
        int         cycles;
        logic [1:0] exp_db;
        logic [3:0] exp_raw0;
        logic [3:0] exp_db0;
        logic [3:0] exp_raw1;
        logic [3:0] exp_db1;
    } vec_t;

    vec_t tbl [17];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int pulses;
        logic [3:0] exp_wrap;
`ifdef DB_COUNT_SAT_EN
        exp_wrap = 4'd15;
`else
        exp_wrap = 4'd1;
`endif
        // ch0 stays high, ch1 pulses: 5 under mode 10, 3 under mode 11, then back to 00.
        for (int p = 0; p < 5; p++) begin
            tbl[2*p]   = '{2'b11, 2'b10, 8, 2'b11, 4'd2, 4'd1, 4'(2*p+1), 4'(2*p+1)};
            tbl[2*p+1] = '{2'b01, 2'b10, 8, 2'b01, 4'd2, 4'd1, 4'(2*p+2), 4'(2*p+2)};
        end
        for (int p = 0; p < 3; p++) begin
            tbl[10+2*p] = '{2'b11, 2'b11, 8, 2'b11, 4'd2, 4'd1, 4'd10, 4'd10};
            tbl[11+2*p] = '{2'b01, 2'b11, 8, 2'b01, 4'd2, 4'd1, 4'd10, 4'd10};
        end
        tbl[16] = '{2'b01, 2'b00, 8, 2'b01, 4'd2, 4'd1, 4'd10, 4'd10};

        i_rst = 1'b1; i_lvl = '0; i_clr = '0; i_mode = 2'b00;
        tick(3);
        check("rst_lvl_db", o_lvl_db, 0);
        check("rst_db_edge", o_db_edge, 0);
        check("rst_raw_count", o_raw_count, 0);
        check("rst_db_count", o_db_count, 0);
        i_rst = 1'b0;
        tick(2);

        // Clean rise on ch0: level must change exactly after edge k+6.
        i_lvl = 2'b01;
        tick(6);
        check("rise_lvl_early", o_lvl_db, 2'b00);
        tick(1);
        check("rise_lvl", o_lvl_db, 2'b01);
        check("rise_edge", o_db_edge, 2'b01);
        check("rise_db_count", o_db_count, 8'h01);
        check("rise_raw_count", o_raw_count, 8'h01);
        $display("rise ch0: lvl_db=%b raw=%h db=%h", o_lvl_db, o_raw_count, o_db_count);
        tick(1);
        check("rise_edge_1cyc", o_db_edge, 2'b00);
        i_lvl = 2'b00;
        tick(10);
        check("fall_lvl", o_lvl_db, 2'b00);
        check("fall_not_counted_db", o_db_count, 8'h01);
        check("fall_not_counted_raw", o_raw_count, 8'h01);

        // Bounce 1-0 then hold high on ch0.
        i_clr = 2'b01; tick(1); i_clr = '0;
        check("clr_ch0_raw", o_raw_count, 8'h00);
        i_lvl = 2'b01; tick(1);
        i_lvl = 2'b00; tick(1);
        i_lvl = 2'b01;
        tick(6);
        check("bounce_lvl_early", o_lvl_db, 2'b00);
        tick(1);
        check("bounce_lvl", o_lvl_db, 2'b01);
        check("bounce_edge", o_db_edge, 2'b01);
        tick(4);
        check("bounce_raw0", o_raw_count[3:0], 4'd2);
        check("bounce_db0", o_db_count[3:0], 4'd1);
        $display("bounce ch0: raw0=%0d db0=%0d", o_raw_count[3:0], o_db_count[3:0]);

        for (int i = 0; i < 17; i++) begin
            i_lvl = tbl[i].lvl;
            i_mode = tbl[i].mode;
            tick(tbl[i].cycles);
            check($sformatf("vec%0d_lvl_db", i), o_lvl_db, tbl[i].exp_db);
            check($sformatf("vec%0d_edge_idle", i), o_db_edge, 2'b00);
            check($sformatf("vec%0d_raw0", i), o_raw_count[3:0], tbl[i].exp_raw0);
            check($sformatf("vec%0d_db0", i), o_db_count[3:0], tbl[i].exp_db0);
            check($sformatf("vec%0d_raw1", i), o_raw_count[7:4], tbl[i].exp_raw1);
            check($sformatf("vec%0d_db1", i), o_db_count[7:4], tbl[i].exp_db1);
            $display("vec %0d: lvl=%b mode=%b lvl_db=%b raw=%h db=%h",
                     i, tbl[i].lvl, tbl[i].mode, o_lvl_db, o_raw_count, o_db_count);
        end

        // 17 rising pulses on ch0: wrap or saturate.
        i_mode = 2'b00; i_lvl = 2'b00;
        tick(8);
        i_clr = 2'b01; tick(1); i_clr = '0;
        pulses = 0;
        for (int p = 0; p < 17; p++) begin
            i_lvl[0] = 1'b1;
            for (int j = 0; j < 8; j++) begin
                tick(1);
                if (o_db_edge[0]) pulses++;
            end
            i_lvl[0] = 1'b0;
            for (int j = 0; j < 8; j++) begin
                tick(1);
                if (o_db_edge[0]) pulses++;
            end
        end
        check("wrap_edge_pulses", pulses, 17);
        check("wrap_raw0", o_raw_count[3:0], exp_wrap);
        check("wrap_db0", o_db_count[3:0], exp_wrap);
        check("wrap_ch1_raw", o_raw_count[7:4], 4'd10);
        $display("17 pulses ch0: pulses=%0d raw0=%0d db0=%0d", pulses, o_raw_count[3:0], o_db_count[3:0]);

        // Clear during the o_db_edge cycle.
        i_lvl[0] = 1'b1;
        tick(7);
        check("clr_edge_seen", o_db_edge, 2'b01);
        i_clr = 2'b01; tick(1); i_clr = '0;
        check("clr_db0", o_db_count[3:0], 4'd0);
        check("clr_raw0", o_raw_count[3:0], 4'd0);
        check("clr_ch1_db", o_db_count[7:4], 4'd10);
        check("clr_ch1_raw", o_raw_count[7:4], 4'd10);

        // Clear on the exact edge the debounced increment lands (falling, mode 01).
        i_mode = 2'b01; i_lvl[0] = 1'b0;
        tick(6);
        i_clr = 2'b01; tick(1); i_clr = '0;
        check("clr_win_edge", o_db_edge, 2'b01);
        check("clr_win_db0", o_db_count[3:0], 4'd0);
        check("clr_win_raw0", o_raw_count[3:0], 4'd0);
        check("clr_win_lvl", o_lvl_db, 2'b00);
        $display("clear vs edge: db0=%0d raw0=%0d", o_db_count[3:0], o_raw_count[3:0]);

        // Async reset while ch0 is in S_WAIT1.
        i_mode = 2'b00; i_lvl[0] = 1'b1;
        tick(4);
        #2 i_rst = 1'b1;
        #1;
        check("arst_lvl_db", o_lvl_db, 2'b00);
        check("arst_raw", o_raw_count, 8'h00);
        check("arst_db", o_db_count, 8'h00);
        tick(2);
        i_rst = 1'b0;
        tick(6);
        check("arst_relvl_early", o_lvl_db, 2'b00);
        tick(1);
        check("arst_relvl", o_lvl_db, 2'b01);
        check("arst_reedge", o_db_edge, 2'b01);
        check("arst_redb0", o_db_count[3:0], 4'd1);
        $display("reset mid-wait: lvl_db=%b db=%h", o_lvl_db, o_db_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
